// File: rtl/uart_peer_echo.sv
// UART link partner: deserializes 8N1 frames on rx, buffers good bytes, re-serializes them on tx.
// Latency: status pulses one clock after the stop sample; echoed start bit two clocks after the good-byte edge.
// Backpressure: none on rx; echo_en gates draining and a full FIFO drops the byte with an overflow pulse.
// Optional even parity is compiled in with the macro UART_PEER_PARITY_EN.
module uart_peer_echo #(
   parameter int SIZE       = 8,
   parameter int BAUD_RATE  = 115200,
   parameter int CLK_FREQ   = 1000000,
   parameter int BAUD_COUNT = CLK_FREQ / BAUD_RATE,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rx,
   input  logic                               echo_en,
   output logic                               tx,
   output logic                               tx_busy,
   output logic [SIZE-1:0]                    rx_data,
   output logic                               rx_valid,
   output logic                               frame_err,
   output logic                               parity_err,
   output logic                               overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int CW = $clog2(BAUD_COUNT);
   localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_COUNT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_COUNT / 2 - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(SIZE - 1);
   localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
   localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- receiver ----------------
   logic            rx_meta, rx_sync;
   state_t          rx_state, rx_next;
   logic [CW-1:0]   rx_cnt;
   logic [BW-1:0]   rx_bit;
   logic [SIZE-1:0] rx_shift;
   logic            rx_tick, stop_tick, rx_good;

   // FIFO / transmitter shared handshakes
   logic            fifo_full, push, pop;
   logic [SIZE-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;

`ifdef UART_PEER_PARITY_EN
   logic            rx_par_bad;
`endif

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // Start bit is sampled at half a bit, every later bit one full bit apart (mid-bit)
   assign rx_tick   = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
   assign stop_tick = (rx_state == S_STOP) && rx_tick;
`ifdef UART_PEER_PARITY_EN
   assign rx_good   = stop_tick && rx_sync && !rx_par_bad;
`else
   assign rx_good   = stop_tick && rx_sync;
`endif

   // RX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_state <= S_IDLE;
      else      rx_state <= rx_next;
   end

   // RX next-state: a high start sample is a glitch and silently returns to IDLE
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:   if (!rx_sync) rx_next = S_START;
         S_START:  if (rx_tick) rx_next = rx_sync ? S_IDLE : S_DATA;
         S_DATA:   if (rx_tick && (rx_bit == DATA_LAST))
`ifdef UART_PEER_PARITY_EN
                      rx_next = S_PARITY;
`else
                      rx_next = S_STOP;
`endif
         S_PARITY: if (rx_tick) rx_next = S_STOP;
         S_STOP:   if (rx_tick) rx_next = S_IDLE;
         default:  rx_next = S_IDLE;
      endcase
   end

   // RX bit timer, bit index and LSB-first shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_cnt <= (rx_state == S_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
         if (rx_state == S_IDLE) rx_bit <= '0;
         if (rx_state == S_DATA && rx_tick) begin
            rx_bit   <= rx_bit + 1'b1;
            rx_shift <= {rx_sync, rx_shift[SIZE-1:1]};
         end
      end
   end

`ifdef UART_PEER_PARITY_EN
   // Even parity: the parity bit must equal the XOR of the data bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  rx_par_bad <= 1'b0;
      else if (rx_state == S_PARITY && rx_tick)  rx_par_bad <= (rx_sync != ^rx_shift);
   end
`endif

   // Registered status pulses; a bad stop bit masks a parity error on the same frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
         rx_data   <= '0;
      end else begin
         rx_valid  <= rx_good;
         frame_err <= stop_tick && !rx_sync;
         overflow  <= rx_good && fifo_full && !pop;
         if (rx_good) rx_data <= rx_shift;
      end
   end

`ifdef UART_PEER_PARITY_EN
   // Parity error pulse, only when the stop bit itself was good
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) parity_err <= 1'b0;
      else      parity_err <= stop_tick && rx_sync && rx_par_bad;
   end
`else
   assign parity_err = 1'b0;
`endif

   // ---------------- echo FIFO ----------------
   state_t          tx_state, tx_next;

   assign fifo_full = (fifo_count == DEPTH_N);
   assign pop       = (tx_state == S_IDLE) && echo_en && (fifo_count != '0);
   assign push      = rx_good && (!fifo_full || pop);

   // Storage needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_shift;
   end

   // Wrapping pointers and occupancy count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   logic [CW-1:0]   tx_cnt;
   logic [BW-1:0]   tx_bit;
   logic [SIZE-1:0] tx_shift;
   logic            tx_tick, tx_line;
`ifdef UART_PEER_PARITY_EN
   logic            tx_par;
`endif

   assign tx_tick = (tx_cnt == BIT_LAST);

   // TX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tx_state <= S_IDLE;
      else      tx_state <= tx_next;
   end

   // TX next-state and line level; echo_en is only looked at in IDLE so frames always complete
   always_comb begin
      tx_next = tx_state;
      tx_line = 1'b1;
      case (tx_state)
         S_IDLE:   if (pop) tx_next = S_START;
         S_START: begin
            tx_line = 1'b0;
            if (tx_tick) tx_next = S_DATA;
         end
         S_DATA: begin
            tx_line = tx_shift[0];
            if (tx_tick && (tx_bit == DATA_LAST))
`ifdef UART_PEER_PARITY_EN
               tx_next = S_PARITY;
`else
               tx_next = S_STOP;
`endif
         end
         S_PARITY: begin
`ifdef UART_PEER_PARITY_EN
            tx_line = tx_par;
`endif
            if (tx_tick) tx_next = S_STOP;
         end
         S_STOP:   if (tx_tick) tx_next = S_IDLE;
         default:  tx_next = S_IDLE;
      endcase
   end

   // TX bit timer, index and shift register loaded from the FIFO head on pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
`ifdef UART_PEER_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_cnt <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
         if (tx_state == S_IDLE) tx_bit <= '0;
         if (pop) begin
            tx_shift <= mem[rd_ptr];
`ifdef UART_PEER_PARITY_EN
            tx_par   <= ^mem[rd_ptr];
`endif
         end else if (tx_state == S_DATA && tx_tick) begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
         end
      end
   end

   // Registered line outputs: glitch-free tx, busy aligned with the frame on the wire
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         tx      <= tx_line;
         tx_busy <= (tx_state != S_IDLE);
      end
   end

endmodule

// File: doc/uart_peer_echo.md
# uart_peer_echo

Self-contained UART link partner that sits on the far end of the serial pair, opposite the UART top-level in the testbench and loopback builds. It deserializes frames arriving on `rx` and buffers good bytes in a small FIFO. It then re-serializes them on `tx` back to the far end, giving a closed-loop echo link. Frame format is 8N1 by default: start bit low, `SIZE` data bits LSB first, one stop bit high. Each bit lasts `BAUD_COUNT` clocks.

## Interface
- `SIZE`, 8, data bits per frame
- `BAUD_RATE`, 115200, line rate (informational; used to derive `BAUD_COUNT`)
- `CLK_FREQ`, 1000000, clock frequency in Hz
- `BAUD_COUNT`, `CLK_FREQ/BAUD_RATE`, clocks per bit; must be >= 4
- `FIFO_DEPTH`, 4, echo buffer entries; power of two

Ports:
- `clk` input 1: single clock; all logic on the rising edge
- `rst` input 1: asynchronous active-low reset
- `rx` input 1: serial in; idles high; asynchronous to `clk`
- `echo_en` input 1: while high, the TX side drains the FIFO
- `tx` output 1: serial out; idles high
- `tx_busy` output 1: high from the first start-bit cycle through the last stop-bit cycle
- `rx_data` output `SIZE`: last good byte received; holds its value until the next good byte
- `rx_valid` output 1: one-cycle pulse when a good byte is captured
- `frame_err` output 1: one-cycle pulse when a stop bit samples low
- `parity_err` output 1: one-cycle pulse on parity mismatch; tied 0 unless parity is compiled in
- `overflow` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full
- `fifo_count` output `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy

## Operation
- **Reset:** applies immediately and asynchronously; reset values are listed under Timing.
- **RX synchronizer:** `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- **RX FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE -> START when the synchronized `rx` is 0; the bit counter clears.
  - START: waits `BAUD_COUNT/2` clocks, then samples. 0 -> DATA. 1 -> IDLE (glitch rejected, no error).
  - DATA: samples every `BAUD_COUNT` clocks and shifts LSB first. After `SIZE` samples -> PARITY or STOP.
  - STOP: samples after `BAUD_COUNT` clocks. 1 -> good byte: push to FIFO, update `rx_data`, pulse `rx_valid`. 0 -> pulse `frame_err`, discard the byte.
  - STOP -> IDLE right after the stop sample, so a back-to-back start bit is accepted.
- **TX FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE -> START when `echo_en`=1 and `fifo_count`>0; the FIFO head is popped into the shift register in the same cycle.
  - Each state drives `tx` for exactly `BAUD_COUNT` clocks.
  - STOP -> IDLE; IDLE lasts at least 1 clock before the next start bit.
  - Deasserting `echo_en` mid-frame does not abort the frame; the frame completes.
- **FIFO:** circular buffer with wrapping read/write pointers.
  - Push while full (and no pop that cycle): byte dropped, `overflow` pulses, `rx_valid` still pulses.
  - Push and pop in the same cycle while full: both succeed; count unchanged.
  - Push and pop in the same cycle while empty: not possible, because pop requires count>0.

## Timing
- **Reset values:** `tx`=1, `tx_busy`=0, `rx_data`=0, `rx_valid`=`frame_err`=`parity_err`=`overflow`=0, `fifo_count`=0, both FSMs in IDLE, FIFO pointers at 0.
- **Start detection:** IDLE->START occurs 2 clocks after `rx` falls (synchronizer latency).
- **RX status pulses:** `rx_valid`/`frame_err`/`parity_err`/`overflow` assert on the clock after the stop sample (registered). `fifo_count` updates on that same edge.
- **TX start:** the first `tx`=0 cycle is the clock after the pop. `tx_busy` rises on that same edge.
- **Frame length:** a frame occupies `(SIZE+2)*BAUD_COUNT` clocks on `tx`, plus `BAUD_COUNT` when parity is enabled.
- **Echo latency** (`echo_en`=1, FIFO empty): the echoed start bit begins 2 clocks after the receiver's good-byte edge.

## Configuration
- **`UART_PEER_PARITY_EN` defined:** both FSMs include the PARITY state with an even-parity bit after the data bits.
  - RX: a mismatch pulses `parity_err` and the byte is discarded (not pushed).
  - If the same frame also has a bad stop bit, only `frame_err` pulses.
  - TX: sends the computed even-parity bit.
- **`UART_PEER_PARITY_EN` not defined:** 8N1 only; `parity_err` is tied to 0.

## Test plan
All scenarios use `BAUD_COUNT`=8 and `SIZE`=8.
- **Basic echo:** `echo_en`=1, drive frame 0xA5 on `rx` -> `rx_valid` pulses once with `rx_data`=0xA5, then `tx` carries 0xA5 as 0,1,0,1,0,0,1,0,1,1 (8 clocks per bit); `tx_busy` high for exactly 80 clocks.
- **Framing error:** drive 0x3C with stop bit 0 -> `frame_err` pulses once, no `rx_valid`, `fifo_count` stays 0, `tx` stays 1.
- **Glitch rejection:** hold `rx` low for 2 clocks only -> no status pulse, RX FSM returns to IDLE, a following 0x55 frame is received correctly.
- **Overflow and order:** `echo_en`=0, send 0x01..0x05 -> `fifo_count`=4, `overflow` pulses on the 5th byte. Then set `echo_en`=1 -> `tx` emits 0x01,0x02,0x03,0x04 in order and `fifo_count` ends at 0.
- **Reset mid-frame:** assert `rst` low midway through an echoed frame -> `tx`=1 and `tx_busy`=0 immediately, `fifo_count`=0. After release, a new 0x7E frame echoes correctly.
- **Parity** (macro defined): 0x07 -> echoed parity bit is 1. A received 0x07 with parity bit 0 -> `parity_err` pulses, no push.
